wb_port_arbiter: RTL

//  Shares the single write port of the 16x16 register file between two writeback sources:
//  the ALU (EX result) and the memory unit (load data).

---
 rtl/wb_port_arbiter_pkg.sv | 23 ++
 rtl/wb_port_arbiter_if.sv | 31 +++
 rtl/wb_port_arbiter_wb_queue.sv | 61 ++++++
 rtl/wb_port_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Register indices follow config.v (zero register, temp, program counter).
package wb_port_arbiter_pkg;

    localparam int REG_W  = 4;
    localparam int DATA_W = 16;
    localparam int NREG   = 16;

    localparam logic [REG_W-1:0] REG0_IDX = 4'd0;
    localparam logic [REG_W-1:0] T_IDX    = 4'd14;
    localparam logic [REG_W-1:0] PC_IDX   = 4'd15;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Writes to the hard-wired zero register or the PC are swallowed.
    function automatic logic is_discard(input logic [REG_W-1:0] rd);
        return (rd == REG0_IDX) || (rd == PC_IDX);
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Writeback request/response bundle between the EX/MEM paths and the arbiter.
interface wb_port_arbiter_if #(parameter int DEPTH = 2);
    import wb_port_arbiter_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_W-1:0]  alu_reg;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [REG_W-1:0]  mem_reg;
    logic [DATA_W-1:0] mem_data;
    logic              RegWre;
    logic [REG_W-1:0]  WriteReg;
    logic [DATA_W-1:0] WriteData;
    logic [NREG-1:0]   reg_busy;
    logic [AW:0]       q_level;

    modport master (
        output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        input  alu_ready, mem_ready, RegWre, WriteReg, WriteData, reg_busy, q_level
    );

    modport slave (
        input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
        output alu_ready, mem_ready, RegWre, WriteReg, WriteData, reg_busy, q_level
    );

endinterface

// File: rtl/wb_port_arbiter_wb_queue.sv
// Ordered overflow FIFO for ALU writebacks; exports which registers have a pending write.
module wb_queue
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     push_i,
    input  wb_req_t                  push_entry_i,
    input  logic                     pop_i,
    output wb_req_t                  head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [NREG-1:0]          busy_o
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t         slot_q [DEPTH];
    logic [AW-1:0]   head_q;
    logic [AW-1:0]   tail_q;
    logic [AW:0]     level_q;
    logic [AW-1:0]   slot_off;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            if (push_i) tail_q <= tail_q + 1'b1;
            if (pop_i)  head_q <= head_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (push_i) slot_q[tail_q] <= push_entry_i;
    end

    // Busy is rebuilt from live slots so duplicate targets clear only on the last pop.
    always_comb begin
        busy_o   = '0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = AW'(i) - head_q;
            if ({1'b0, slot_off} < level_q) busy_o[slot_q[i].rd] = 1'b1;
        end
    end

    assign head_o  = slot_q[head_q];
    assign level_o = level_q;
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Single register-file write port shared by the MEM (load) and ALU writeback paths.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    wb_req_t           q_head;
    logic [AW:0]       q_level;
    logic              q_full;
    logic              q_empty;
    logic [NREG-1:0]   q_busy;

    logic              alu_acc, mem_acc, alu_keep, mem_keep;
    logic              push, pop, direct;

    logic              wre_d, wre_q;
    logic [REG_W-1:0]  wreg_d, wreg_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .Clk          (Clk),
        .Rst          (Rst),
        .push_i       (push),
        .push_entry_i ('{rd: bus.alu_reg, data: bus.alu_data}),
        .pop_i        (pop),
        .head_o       (q_head),
        .level_o      (q_level),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .busy_o       (q_busy)
    );

    assign bus.alu_ready = !q_full;
    assign bus.mem_ready = !q_busy[bus.mem_reg];

    // MEM is the older instruction, then queued ALU work, then a direct ALU bypass.
    always_comb begin
        alu_acc  = bus.alu_valid & bus.alu_ready;
        mem_acc  = bus.mem_valid & bus.mem_ready;
        alu_keep = alu_acc & !is_discard(bus.alu_reg);
        mem_keep = mem_acc & !is_discard(bus.mem_reg);
        pop      = !mem_keep & !q_empty;
        direct   = !mem_keep & q_empty & alu_keep;
        push     = alu_keep & !direct;
        wre_d    = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        if (mem_keep) begin
            wre_d   = 1'b1;
            wreg_d  = bus.mem_reg;
            wdata_d = bus.mem_data;
        end else if (pop) begin
            wre_d   = 1'b1;
            wreg_d  = q_head.rd;
            wdata_d = q_head.data;
        end else if (direct) begin
            wre_d   = 1'b1;
            wreg_d  = bus.alu_reg;
            wdata_d = bus.alu_data;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wre_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            wre_q   <= wre_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.RegWre    = wre_q;
    assign bus.WriteReg  = wreg_q;
    assign bus.WriteData = wdata_q;
    assign bus.reg_busy  = q_busy;
    assign bus.q_level   = q_level;

endmodule
